// File: rtl/hazard_forward_unit.sv
// rtl/hazard_forward_unit.sv - RV32I operand forward selects, data-hazard stalls/flush and perf counters
module hazard_forward_unit #(
  parameter int REG_AW         = 5,
  parameter int FWD_EX         = 1,
  parameter int LOAD_STALL_CYC = 1,
  parameter int MULDIV_LAT     = 4,
  parameter int CNT_W          = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [REG_AW-1:0] Rs1_ID,
  input  logic [REG_AW-1:0] Rs2_ID,
  input  logic              Rs1_Used,
  input  logic              Rs2_Used,
  input  logic [REG_AW-1:0] Rd_EX,
  input  logic [REG_AW-1:0] Rd_MA,
  input  logic [REG_AW-1:0] Rd_WB,
  input  logic              EX_RegWEN,
  input  logic              MA_RegWEN,
  input  logic              WB_RegWEN,
  input  logic              EX_MemRead,
  input  logic              EX_MulDiv,
  input  logic              Br_Taken_EX,
  output logic [1:0]        Fw_1,
  output logic [1:0]        Fw_2,
  output logic [1:0]        Fw_Detected,
  output logic              Stall_IF,
  output logic              Stall_ID,
  output logic              Stall_EX,
  output logic              Bubble_EX,
  output logic              Bubble_MA,
  output logic              Flush_ID,
  output logic [CNT_W-1:0]  Stall_Count,
  output logic [CNT_W-1:0]  Fw_Count
);

  localparam int CW = $clog2(MULDIV_LAT + LOAD_STALL_CYC);
  // Without EX forwarding a load result needs one extra cycle before MA can supply it.
  localparam int LD_TOTAL = LOAD_STALL_CYC + ((FWD_EX == 0) ? 1 : 0);
  localparam logic [CW-1:0] LD_CNT = CW'((LD_TOTAL > 1) ? LD_TOTAL - 2 : 0);
  localparam logic [CW-1:0] MD_CNT = CW'((MULDIV_LAT > 1) ? MULDIV_LAT - 2 : 0);

  typedef enum logic [1:0] {IDLE, LD_STALL, MD_BUSY} state_t;

  state_t        state, state_next;
  logic [CW-1:0] cnt, cnt_next;

  logic ex_m1, ex_m2, ma_m1, ma_m2, wb_m1, wb_m2;
  logic ex_fwd_ok, hz;
  logic [1:0] fw_inc;
  logic [CNT_W:0] fc_sum;

  assign ex_m1 = EX_RegWEN && (Rd_EX != '0) && Rs1_Used && (Rd_EX == Rs1_ID);
  assign ex_m2 = EX_RegWEN && (Rd_EX != '0) && Rs2_Used && (Rd_EX == Rs2_ID);
  assign ma_m1 = MA_RegWEN && (Rd_MA != '0) && Rs1_Used && (Rd_MA == Rs1_ID);
  assign ma_m2 = MA_RegWEN && (Rd_MA != '0) && Rs2_Used && (Rd_MA == Rs2_ID);
  assign wb_m1 = WB_RegWEN && (Rd_WB != '0) && Rs1_Used && (Rd_WB == Rs1_ID);
  assign wb_m2 = WB_RegWEN && (Rd_WB != '0) && Rs2_Used && (Rd_WB == Rs2_ID);

  assign ex_fwd_ok = (FWD_EX != 0) && !EX_MemRead && !EX_MulDiv && (state == IDLE);
  assign hz        = (ex_m1 || ex_m2) && (EX_MemRead || (FWD_EX == 0));

  function automatic logic [1:0] fw_sel(input logic ex_hit, input logic ma_hit, input logic wb_hit);
    if (ex_hit)      return 2'b11;
    else if (ma_hit) return 2'b10;
    else if (wb_hit) return 2'b01;
    return 2'b00;
  endfunction

  always_comb begin
    state_next  = state;
    cnt_next    = cnt;
    Stall_IF    = 1'b0;
    Stall_ID    = 1'b0;
    Stall_EX    = 1'b0;
    Bubble_EX   = 1'b0;
    Bubble_MA   = 1'b0;
    Flush_ID    = 1'b0;
    Fw_1        = fw_sel(ex_m1 && ex_fwd_ok, ma_m1, wb_m1);
    Fw_2        = fw_sel(ex_m2 && ex_fwd_ok, ma_m2, wb_m2);
    case (state)
      IDLE: begin
        // A taken branch kills the younger instruction, so any hazard it carries is moot.
        if (Br_Taken_EX) begin
          Flush_ID  = 1'b1;
          Bubble_EX = 1'b1;
        end else if (EX_MulDiv) begin
          Stall_IF  = 1'b1;
          Stall_ID  = 1'b1;
          Stall_EX  = 1'b1;
          Bubble_MA = 1'b1;
          if (MULDIV_LAT > 1) begin
            state_next = MD_BUSY;
            cnt_next   = MD_CNT;
          end
        end else if (hz) begin
          Stall_IF  = 1'b1;
          Stall_ID  = 1'b1;
          Bubble_EX = 1'b1;
          if (EX_MemRead && (LD_TOTAL > 1)) begin
            state_next = LD_STALL;
            cnt_next   = LD_CNT;
          end
        end
      end
      LD_STALL: begin
        Stall_IF  = 1'b1;
        Stall_ID  = 1'b1;
        Bubble_EX = 1'b1;
        if (cnt == '0) state_next = IDLE;
        else           cnt_next   = cnt - CW'(1);
      end
      MD_BUSY: begin
        Stall_IF  = 1'b1;
        Stall_ID  = 1'b1;
        Stall_EX  = 1'b1;
        Bubble_MA = 1'b1;
        if (cnt == '0) state_next = IDLE;
        else           cnt_next   = cnt - CW'(1);
      end
      default: state_next = IDLE;
    endcase
    // Outputs are held low for the whole time reset is asserted, not just after the next edge.
    if (!rst_n) begin
      Fw_1      = 2'b00;
      Fw_2      = 2'b00;
      Stall_IF  = 1'b0;
      Stall_ID  = 1'b0;
      Stall_EX  = 1'b0;
      Bubble_EX = 1'b0;
      Bubble_MA = 1'b0;
      Flush_ID  = 1'b0;
    end
    Fw_Detected = {(Fw_2 != 2'b00), (Fw_1 != 2'b00)};
  end

  assign fw_inc = {1'b0, Fw_Detected[0]} + {1'b0, Fw_Detected[1]};
  assign fc_sum = {1'b0, Fw_Count} + (CNT_W + 1)'(fw_inc);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      cnt         <= '0;
      Stall_Count <= '0;
      Fw_Count    <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
      if (Stall_IF && (Stall_Count != {CNT_W{1'b1}}))
        Stall_Count <= Stall_Count + CNT_W'(1);
      Fw_Count <= fc_sum[CNT_W] ? {CNT_W{1'b1}} : fc_sum[CNT_W-1:0];
    end
  end

endmodule

// File: tb/tb_hazard_forward_unit.sv
// tb/tb_hazard_forward_unit.sv - directed scoreboard bench for hazard_forward_unit
module tb_hazard_forward_unit;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [4:0] Rs1_ID, Rs2_ID, Rd_EX, Rd_MA, Rd_WB;
  logic       Rs1_Used, Rs2_Used, EX_RegWEN, MA_RegWEN, WB_RegWEN;
  logic       EX_MemRead, EX_MulDiv, Br_Taken_EX;
  logic [1:0] Fw_1, Fw_2, Fw_Detected;
  logic       Stall_IF, Stall_ID, Stall_EX, Bubble_EX, Bubble_MA, Flush_ID;
  logic [3:0] Stall_Count, Fw_Count;

  hazard_forward_unit #(
    .REG_AW(5), .FWD_EX(1), .LOAD_STALL_CYC(2), .MULDIV_LAT(4), .CNT_W(4)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .Rs1_ID(Rs1_ID), .Rs2_ID(Rs2_ID), .Rs1_Used(Rs1_Used), .Rs2_Used(Rs2_Used),
    .Rd_EX(Rd_EX), .Rd_MA(Rd_MA), .Rd_WB(Rd_WB),
    .EX_RegWEN(EX_RegWEN), .MA_RegWEN(MA_RegWEN), .WB_RegWEN(WB_RegWEN),
    .EX_MemRead(EX_MemRead), .EX_MulDiv(EX_MulDiv), .Br_Taken_EX(Br_Taken_EX),
    .Fw_1(Fw_1), .Fw_2(Fw_2), .Fw_Detected(Fw_Detected),
    .Stall_IF(Stall_IF), .Stall_ID(Stall_ID), .Stall_EX(Stall_EX),
    .Bubble_EX(Bubble_EX), .Bubble_MA(Bubble_MA), .Flush_ID(Flush_ID),
    .Stall_Count(Stall_Count), .Fw_Count(Fw_Count)
  );

  always #5 clk = ~clk;

  // ctl = {Stall_IF, Stall_ID, Stall_EX, Bubble_EX, Bubble_MA, Flush_ID}
  localparam logic [5:0] NONE = 6'b000000;
  localparam logic [5:0] LD   = 6'b110100;
  localparam logic [5:0] MD   = 6'b111010;
  localparam logic [5:0] BR   = 6'b000101;

  typedef struct {
    string      tag;
    logic [11:0] out;
    bit          cc;
    logic [3:0]  sc;
    logic [3:0]  fc;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;

  function automatic logic [11:0] ex(input logic [1:0] f1, input logic [1:0] f2, input logic [5:0] ctl);
    return {f1, f2, (f2 != 2'b00), (f1 != 2'b00), ctl};
  endfunction

  task automatic clr();
    Rs1_ID = 0; Rs2_ID = 0; Rd_EX = 0; Rd_MA = 0; Rd_WB = 0;
    Rs1_Used = 0; Rs2_Used = 0; EX_RegWEN = 0; MA_RegWEN = 0; WB_RegWEN = 0;
    EX_MemRead = 0; EX_MulDiv = 0; Br_Taken_EX = 0;
  endtask

  task automatic push(input string tag, input logic [11:0] eo, input bit cc,
                      input logic [3:0] esc, input logic [3:0] efc);
    exp_t e;
    e.tag = tag; e.out = eo; e.cc = cc; e.sc = esc; e.fc = efc;
    sb.push_back(e);
  endtask

  task automatic check_front();
    exp_t e;
    logic [11:0] obs;
    e   = sb.pop_front();
    obs = {Fw_1, Fw_2, Fw_Detected, Stall_IF, Stall_ID, Stall_EX, Bubble_EX, Bubble_MA, Flush_ID};
    checks++;
    assert (obs === e.out) else begin
      errors++;
      $error("FAIL %s outputs observed=%b expected=%b", e.tag, obs, e.out);
    end
    if (e.cc) begin
      checks++;
      assert ({Stall_Count, Fw_Count} === {e.sc, e.fc}) else begin
        errors++;
        $error("FAIL %s counters observed stall=%0d fw=%0d expected stall=%0d fw=%0d",
               e.tag, Stall_Count, Fw_Count, e.sc, e.fc);
      end
    end
  endtask

  task automatic step(input string tag, input logic [11:0] eo, input bit cc,
                      input logic [3:0] esc, input logic [3:0] efc);
    push(tag, eo, cc, esc, efc);
    @(negedge clk);
    check_front();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    clr();
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  // A taken branch must only ever arrive while the unit is idle, i.e. never during a stall.
  always @(negedge clk) begin
    if (rst_n && Br_Taken_EX) begin
      checks++;
      assert (Stall_IF === 1'b0) else begin
        errors++;
        $error("FAIL br_not_idle observed Stall_IF=%b expected 0", Stall_IF);
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    clr();
    Rd_EX = 1; EX_RegWEN = 1; Rs1_ID = 1; Rs1_Used = 1; EX_MemRead = 1; EX_MulDiv = 1;
    step("reset", ex(2'b00, 2'b00, NONE), 1, 0, 0);

    rst_n = 1'b1;
    clr();
    Rd_EX = 1; EX_RegWEN = 1; Rs1_ID = 1; Rs2_ID = 3; Rs1_Used = 1; Rs2_Used = 1;
    step("dflt_a", ex(2'b11, 2'b00, NONE), 1, 0, 0);
    step("dflt_b", ex(2'b11, 2'b00, NONE), 1, 0, 1);

    Rd_EX = 5; Rd_MA = 5; Rd_WB = 5; MA_RegWEN = 1; WB_RegWEN = 1; Rs1_ID = 5; Rs2_ID = 5;
    step("prio_ex", ex(2'b11, 2'b11, NONE), 1, 0, 2);
    EX_RegWEN = 0;
    step("prio_ma", ex(2'b10, 2'b10, NONE), 1, 0, 4);
    MA_RegWEN = 0;
    step("prio_wb", ex(2'b01, 2'b01, NONE), 1, 0, 6);

    Rd_EX = 0; Rd_MA = 0; Rd_WB = 0; Rs1_ID = 0; Rs2_ID = 0;
    EX_RegWEN = 1; MA_RegWEN = 1; WB_RegWEN = 1; EX_MemRead = 1;
    step("x0_a", ex(2'b00, 2'b00, NONE), 1, 0, 8);
    step("x0_b", ex(2'b00, 2'b00, NONE), 1, 0, 8);

    do_reset();
    EX_MemRead = 1; EX_RegWEN = 1; Rd_EX = 7; Rs1_ID = 7; Rs1_Used = 1;
    Rs2_ID = 4; Rs2_Used = 1; Rd_MA = 4; MA_RegWEN = 1;
    step("ld_c1", ex(2'b00, 2'b10, LD), 1, 0, 0);
    Rd_EX = 0; EX_RegWEN = 0; EX_MemRead = 0; Rd_MA = 7; Rd_WB = 4; WB_RegWEN = 1;
    step("ld_c2", ex(2'b10, 2'b01, LD), 1, 1, 1);
    step("ld_c3", ex(2'b10, 2'b01, NONE), 1, 2, 3);
    clr();
    step("ld_c4", ex(2'b00, 2'b00, NONE), 1, 2, 5);

    do_reset();
    EX_MulDiv = 1; EX_MemRead = 1; EX_RegWEN = 1; Rd_EX = 9; Rs1_ID = 9; Rs1_Used = 1;
    step("md_c1", ex(2'b00, 2'b00, MD), 1, 0, 0);
    EX_MulDiv = 0; EX_MemRead = 0;
    step("md_c2", ex(2'b00, 2'b00, MD), 1, 1, 0);
    step("md_c3", ex(2'b00, 2'b00, MD), 1, 2, 0);
    step("md_c4", ex(2'b00, 2'b00, MD), 1, 3, 0);
    Rd_EX = 0; EX_RegWEN = 0; Rd_MA = 9; MA_RegWEN = 1;
    step("md_done", ex(2'b10, 2'b00, NONE), 1, 4, 0);
    clr();
    step("md_after", ex(2'b00, 2'b00, NONE), 1, 4, 1);

    do_reset();
    EX_MulDiv = 1;
    step("mdr_c1", ex(2'b00, 2'b00, MD), 1, 0, 0);
    EX_MulDiv = 0;
    push("mdr_c2", ex(2'b00, 2'b00, MD), 1, 1, 0);
    @(negedge clk);
    check_front();
    #2 rst_n = 1'b0;
    EX_MulDiv = 1;
    #1 push("mdr_in_rst", ex(2'b00, 2'b00, NONE), 1, 0, 0);
    check_front();
    @(posedge clk); #1;
    EX_MulDiv = 0;
    rst_n = 1'b1;
    step("mdr_idle", ex(2'b00, 2'b00, NONE), 1, 0, 0);
    Rd_EX = 1; EX_RegWEN = 1; Rs1_ID = 1; Rs1_Used = 1;
    step("mdr_exfwd", ex(2'b11, 2'b00, NONE), 1, 0, 0);

    do_reset();
    Br_Taken_EX = 1; EX_MemRead = 1; EX_RegWEN = 1; Rd_EX = 7; Rs1_ID = 7; Rs1_Used = 1;
    step("br_flush", ex(2'b00, 2'b00, BR), 1, 0, 0);
    Br_Taken_EX = 0; EX_MemRead = 0; Rd_EX = 2; Rs1_ID = 2;
    step("br_idle", ex(2'b11, 2'b00, NONE), 1, 0, 0);

    do_reset();
    EX_MemRead = 1; EX_RegWEN = 1; Rd_EX = 7; Rs1_ID = 7; Rs1_Used = 1;
    for (int i = 0; i < 20; i++)
      step($sformatf("sat_st_%0d", i), ex(2'b00, 2'b00, LD), 0, 0, 0);
    step("sat_stall", ex(2'b00, 2'b00, LD), 1, 15, 0);

    do_reset();
    EX_RegWEN = 1; Rd_EX = 5; Rs1_ID = 5; Rs2_ID = 5; Rs1_Used = 1; Rs2_Used = 1;
    for (int i = 0; i < 7; i++)
      step($sformatf("sat_fw_%0d", i), ex(2'b11, 2'b11, NONE), 0, 0, 0);
    step("sat_fw_14", ex(2'b11, 2'b11, NONE), 1, 0, 14);
    step("sat_fw_15", ex(2'b11, 2'b11, NONE), 1, 0, 15);
    step("sat_fw_hold", ex(2'b11, 2'b11, NONE), 1, 0, 15);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
